param_shift_serializer: RTL

- Parametrised successor to the fixed 256-bit shift register with reset-value load.
- Accepts a parallel word over a valid/ready load handshake, then shifts it out serially, MSB- or LSB-first, one bit per SHIFT_EN tick.
- Simultaneously captures SER_IN into the vacated end, then returns the received word with a one-cycle DONE pulse.
- Used between game logic and serial peripherals (LED strips, display columns, pad readers) driven by a divided-clock enable.

---
 rtl/shift_ser_pkg.sv | 21 ++
 rtl/param_shift_serializer_if.sv | 33 +++
 rtl/shift_bit_counter.sv | 27 ++
 rtl/param_shift_serializer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/shift_ser_pkg.sv
// Shared definitions for the parametrised shift serializer.
//   state_e   : FSM states (IDLE, SHIFT)
//   DIR_LSB / DIR_MSB : latched shift-direction encodings
//   cnt_width : bit-counter width for a given register length, never below 1
package shift_ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_LSB = 1'b0;
  localparam logic DIR_MSB = 1'b1;

  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/param_shift_serializer_if.sv
// Parallel-load handshake bundle for param_shift_serializer.
//   LOAD_VALID / LOAD_READY : valid/ready handshake (ready only while idle)
//   LOAD_DATA               : word to transmit
//   MSB_FIRST               : direction, sampled at acceptance
//   ROTATE                  : recirculate outgoing bit (only with SHIFT_SER_ROTATE_EN)
// master = upstream producer, slave = serializer.
interface param_shift_serializer_if #(
  parameter int WIDTH = 256
);
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic [WIDTH-1:0] LOAD_DATA;
  logic             MSB_FIRST;
`ifdef SHIFT_SER_ROTATE_EN
  logic             ROTATE;
`endif

  modport master (
`ifdef SHIFT_SER_ROTATE_EN
    output ROTATE,
`endif
    output LOAD_VALID, LOAD_DATA, MSB_FIRST,
    input  LOAD_READY
  );

  modport slave (
`ifdef SHIFT_SER_ROTATE_EN
    input  ROTATE,
`endif
    input  LOAD_VALID, LOAD_DATA, MSB_FIRST,
    output LOAD_READY
  );
endinterface

// File: rtl/shift_bit_counter.sv
// Shifted-bit counter for the serializer.
//   CLK, RESET : clock, synchronous active-high reset
//   i_clr      : clear to 0 (wins over i_en)
//   i_en       : increment by one
//   o_tc       : terminal count, high while count == WIDTH-1
module shift_bit_counter
  import shift_ser_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RESET)      r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_tc = (r_cnt == CNT_W'(WIDTH - 1));
endmodule

// File: rtl/param_shift_serializer.sv
// Parametrised parallel-in / serial-out shift register with simultaneous
// serial capture. A word accepted over the load handshake is shifted out
// one bit per SHIFT_EN, MSB- or LSB-first, while SER_IN fills the vacated
// end; after WIDTH shifts the captured word appears on RX_DATA with a
// one-cycle DONE pulse.
//   CLK, RESET : clock, synchronous active-high reset
//   ld         : load handshake (param_shift_serializer_if.slave)
//   SHIFT_EN   : one-bit shift strobe
//   ABORT      : cancel transfer in progress (no DONE, RX_DATA kept)
//   SER_IN     : serial input      SER_OUT : serial output (0 while idle)
//   BUSY       : in SHIFT state    DONE    : transfer-complete pulse
//   RX_DATA    : word captured on last completion
// Optional: SHIFT_SER_ROTATE_EN adds ld.ROTATE; when latched high the
// outgoing bit is fed back instead of SER_IN, so the word recirculates.
module param_shift_serializer
  import shift_ser_pkg::*;
#(
  parameter int WIDTH = 256,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  param_shift_serializer_if.slave  ld,
  input  logic                     SHIFT_EN,
  input  logic                     ABORT,
  input  logic                     SER_IN,
  output logic                     SER_OUT,
  output logic                     BUSY,
  output logic                     DONE,
  output logic [WIDTH-1:0]         RX_DATA
);
  state_e           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_rx;
  logic             r_dir;
  logic             r_done;

  logic             w_accept;
  logic             w_shift;
  logic             w_abort;
  logic             w_tc;
  logic             w_last;
  logic             w_out_bit;
  logic             w_in_bit;
  logic [WIDTH-1:0] w_next;

  assign w_accept  = (r_state == IDLE)  && ld.LOAD_VALID;
  // ABORT takes priority, so a shift only happens without it.
  assign w_shift   = (r_state == SHIFT) && SHIFT_EN && !ABORT;
  assign w_abort   = (r_state == SHIFT) && ABORT;
  assign w_last    = w_shift && w_tc;
  assign w_out_bit = (r_dir == DIR_MSB) ? r_shreg[WIDTH-1] : r_shreg[0];

`ifdef SHIFT_SER_ROTATE_EN
  logic r_rot;
  always_ff @(posedge CLK) begin
    if (RESET)         r_rot <= 1'b0;
    else if (w_accept) r_rot <= ld.ROTATE;
  end
  assign w_in_bit = r_rot ? w_out_bit : SER_IN;
`else
  assign w_in_bit = SER_IN;
`endif

  assign w_next = (r_dir == DIR_MSB) ? {r_shreg[WIDTH-2:0], w_in_bit}
                                     : {w_in_bit, r_shreg[WIDTH-1:1]};

  // Counter is cleared on completion as well, so it can never pass WIDTH-1
  // even when WIDTH is not a power of two.
  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .CLK   (CLK),
    .RESET (RESET),
    .i_clr (w_accept || w_abort || w_last),
    .i_en  (w_shift),
    .o_tc  (w_tc)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_rx    <= '0;
      r_dir   <= DIR_MSB;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= ld.LOAD_DATA;
            r_dir   <= ld.MSB_FIRST;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_abort) begin
            r_state <= IDLE;
          end else if (w_shift) begin
            r_shreg <= w_next;
            if (w_last) begin
              r_rx    <= w_next;
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ld.LOAD_READY = (r_state == IDLE);
  assign BUSY          = (r_state == SHIFT);
  assign SER_OUT       = (r_state == SHIFT) && w_out_bit;
  assign DONE          = r_done;
  assign RX_DATA       = r_rx;
endmodule
